controller_input: RTL and testbench

- Front-end for the two game controllers wired to the GPIO header. Sits directly upstream of the memory-mapped I/O block and produces the controller words the processor reads.
- Synchronises the raw pins, debounces each button, and latches press events until software reads them.
- Exposes a 4-word registered read port that the MMIO address decoder maps into dmem space.

---
 rtl/controller_input_if.sv | 21 ++
 rtl/controller_input.sv | 138 +++++++++++++
 tb/tb_controller_input.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/controller_input_if.sv
// ---------------------------------------------------------------------------
// controller_input_if
//
// Read bus between the MMIO address decoder and the controller front-end.
//
//   rd_en   : read strobe, driven by the decoder
//   rd_addr : register select (4 words), driven by the decoder
//   rd_data : registered read data, driven by the controller front-end
//
// Modports:
//   master : MMIO decoder side (drives the strobe and address)
//   slave  : controller_input side (returns the data)
// ---------------------------------------------------------------------------
interface controller_input_if;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/controller_input.sv
// ---------------------------------------------------------------------------
// controller_input
//
// Front-end for the two game controllers on the GPIO header. It synchronises
// the raw active-low pins, debounces each button independently, latches
// press events until software reads them, and exposes a 4-word registered
// read port that the MMIO decoder maps into dmem space.
//
// Ports:
//   clock         : system clock, all flops rising-edge
//   reset_n       : asynchronous active-low reset
//   gpio_in       : raw pins, 0 = pressed; [NUM_BTNS-1:0] player 1,
//                   [2*NUM_BTNS-1:NUM_BTNS] player 2
//   bus           : read port (rd_en, rd_addr in; rd_data out, 1-cycle latency)
//   p1_state      : player 1 debounced levels, 1 = pressed
//   p2_state      : player 2 debounced levels, 1 = pressed
//   event_pending : OR of every latched press-event flag
//
// Register map (unused upper bits read 0):
//   0 : {p2_state, p1_state}
//   1 : player 1 press flags, cleared by the read
//   2 : player 2 press flags, cleared by the read
//   3 : {16'hC0DE, 14'b0, any button pressed, event_pending}
// ---------------------------------------------------------------------------
module controller_input #(
  parameter int NUM_BTNS        = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2*NUM_BTNS-1:0]   gpio_in,
  controller_input_if.slave       bus,
  output logic [NUM_BTNS-1:0]     p1_state,
  output logic [NUM_BTNS-1:0]     p2_state,
  output logic                    event_pending
);

  localparam int TOTAL = 2 * NUM_BTNS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [TOTAL-1:0]    r_syncMeta;
  logic [TOTAL-1:0]    r_syncPin;
  logic [TOTAL-1:0]    r_stable;
  logic [NUM_BTNS-1:0] r_evtP1;
  logic [NUM_BTNS-1:0] r_evtP2;
  logic [31:0]         r_rdData;

  logic [TOTAL-1:0]    w_sync;
  logic [TOTAL-1:0]    w_done;
  logic [TOTAL-1:0]    w_rise;
  logic                w_clrP1;
  logic                w_clrP2;
  logic                w_pending;

  // Two-flop synchroniser. Flops reset to 1 so every button starts released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_syncMeta <= '1;
      r_syncPin  <= '1;
    end else begin
      r_syncMeta <= gpio_in;
      r_syncPin  <= r_syncMeta;
    end
  end

  assign w_sync = ~r_syncPin;

  // One debounce counter per button. The counter only runs while the synced
  // level disagrees with the accepted level; any agreement (a bounce back)
  // restarts it from zero. w_done marks the cycle the new level is accepted.
  for (genvar i = 0; i < TOTAL; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (w_sync[i] == r_stable[i]) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_done[i] = (w_sync[i] != r_stable[i]) && (r_cnt == CNT_MAX);
  end

  // An accepted change is always a flip of the stable bit, because w_done is
  // only asserted while sync and stable differ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_stable ^ w_done;
    end
  end

  assign w_rise  = w_done & w_sync;
  assign w_clrP1 = bus.rd_en && (bus.rd_addr == 2'd1);
  assign w_clrP2 = bus.rd_en && (bus.rd_addr == 2'd2);

  // Sticky press flags. The set term is OR-ed in after the clear, so a press
  // accepted on the same edge as a clear-on-read survives for the next read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_evtP1 <= '0;
      r_evtP2 <= '0;
    end else begin
      r_evtP1 <= (r_evtP1 & ~{NUM_BTNS{w_clrP1}}) | w_rise[NUM_BTNS-1:0];
      r_evtP2 <= (r_evtP2 & ~{NUM_BTNS{w_clrP2}}) | w_rise[TOTAL-1:NUM_BTNS];
    end
  end

  assign w_pending = (|r_evtP1) | (|r_evtP2);

  // Registered read port. Only registered state feeds the mux, so there is
  // no combinational path from any input to rd_data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdData <= '0;
    end else if (bus.rd_en) begin
      case (bus.rd_addr)
        2'd0:    r_rdData <= 32'(r_stable);
        2'd1:    r_rdData <= 32'(r_evtP1);
        2'd2:    r_rdData <= 32'(r_evtP2);
        default: r_rdData <= {16'hC0DE, 14'd0, |r_stable, w_pending};
      endcase
    end
  end

  assign bus.rd_data    = r_rdData;
  assign p1_state       = r_stable[NUM_BTNS-1:0];
  assign p2_state       = r_stable[TOTAL-1:NUM_BTNS];
  assign event_pending  = w_pending;

endmodule

// File: tb/tb_controller_input.sv
// ---------------------------------------------------------------------------
// tb_controller_input
//
// Self-checking bench for controller_input with a short debounce window.
// Read expectations go into a scoreboard queue when the read is issued and
// are popped and compared once the registered data is available.
// ---------------------------------------------------------------------------
module tb_controller_input;

  localparam int NUM_BTNS = 8;
  localparam int DEB      = 4;
  localparam int CNT_W    = 3;

  logic                  clock;
  logic                  reset_n;
  logic [2*NUM_BTNS-1:0] gpio_in;
  logic [NUM_BTNS-1:0]   p1_state;
  logic [NUM_BTNS-1:0]   p2_state;
  logic                  event_pending;

  controller_input_if bus ();

  controller_input #(
    .NUM_BTNS        (NUM_BTNS),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .gpio_in       (gpio_in),
    .bus           (bus.slave),
    .p1_state      (p1_state),
    .p2_state      (p2_state),
    .event_pending (event_pending)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ[$];
  string       tagQ[$];

  // Free-running clock; all driving and sampling happens on the falling edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [2*NUM_BTNS-1:0] pins, input int cycles);
    gpio_in = pins;
    tick(cycles);
  endtask

  // Issue one read and score the returned word one edge later.
  task automatic readReg(input logic [1:0] addr, input logic [31:0] exp,
                         input string tag);
    logic [31:0] e;
    string       t;
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    tick(1);
    bus.rd_en = 1'b0;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput(t, bus.rd_data, e);
  endtask

  initial begin
    bit seenHigh;

    reset_n     = 1'b0;
    gpio_in     = 16'hFFFF;
    bus.rd_en   = 1'b0;
    bus.rd_addr = 2'd0;

    // Reset state
    tick(3);
    checkOutput("rstP1", 32'(p1_state), 32'h0);
    checkOutput("rstPend", 32'(event_pending), 32'h0);
    checkOutput("rstRd", bus.rd_data, 32'h0);
    reset_n = 1'b1;
    tick(2);
    readReg(2'd0, 32'h0, "idleLevels");
    readReg(2'd3, 32'hC0DE0000, "idleStatus");

    // Debounced press: accepted exactly DEB+2 edges after the pin changes
    applyStimulus(16'hFFFE, DEB + 1);
    checkOutput("pressEarly", 32'(p1_state), 32'h0);
    tick(1);
    checkOutput("pressLevel", 32'(p1_state), 32'h1);
    checkOutput("pressPend", 32'(event_pending), 32'h1);
    readReg(2'd1, 32'h1, "pressEvt");
    readReg(2'd1, 32'h0, "pressEvtClr");
    readReg(2'd0, 32'h1, "pressHeld");
    readReg(2'd3, 32'hC0DE0002, "pressStatus");

    // Release produces no event
    applyStimulus(16'hFFFF, 10);
    checkOutput("relLevel", 32'(p1_state), 32'h0);
    readReg(2'd1, 32'h0, "relNoEvt");

    // Glitch shorter than the debounce window is rejected
    applyStimulus(16'hFDFF, DEB - 1);
    applyStimulus(16'hFFFF, 10);
    checkOutput("glitchLevel", 32'(p2_state), 32'h0);
    checkOutput("glitchPend", 32'(event_pending), 32'h0);
    readReg(2'd2, 32'h0, "glitchEvt");

    // A pulse of exactly the debounce window is accepted, then released
    applyStimulus(16'hFDFF, DEB);
    gpio_in  = 16'hFFFF;
    seenHigh = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (p2_state[1]) seenHigh = 1'b1;
    end
    checkOutput("pulseSeen", 32'(seenHigh), 32'h1);
    checkOutput("pulseEnd", 32'(p2_state), 32'h0);
    checkOutput("pulsePend", 32'(event_pending), 32'h1);
    readReg(2'd2, 32'h2, "pulseEvt");

    // Clear-on-read on the same edge the press is accepted
    applyStimulus(16'hFFF7, DEB + 1);
    readReg(2'd1, 32'h0, "collideRd");
    checkOutput("collideLevel", 32'(p1_state), 32'h8);
    readReg(2'd1, 32'h8, "collideKept");
    applyStimulus(16'hFFFF, 10);
    readReg(2'd1, 32'h0, "collideRel");

    // Reset with events pending and a count in progress
    applyStimulus(16'hFFFA, 10);
    readReg(2'd0, 32'h5, "preRstLevel");
    checkOutput("preRstPend", 32'(event_pending), 32'h1);
    applyStimulus(16'hFFEA, 2);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstP1", 32'(p1_state), 32'h0);
    checkOutput("midRstPend", 32'(event_pending), 32'h0);
    checkOutput("midRstRd", bus.rd_data, 32'h0);
    tick(1);
    reset_n = 1'b1;
    readReg(2'd1, 32'h0, "postRstEvt");
    tick(8);
    readReg(2'd1, 32'h15, "heldThroughRst");
    applyStimulus(16'hFFFF, 10);
    readReg(2'd1, 32'h0, "heldRelease");

    // Every button at once
    applyStimulus(16'h0000, 10);
    readReg(2'd0, 32'hFFFF, "allLevels");
    readReg(2'd1, 32'hFF, "allP1");
    checkOutput("allPendMid", 32'(event_pending), 32'h1);
    readReg(2'd2, 32'hFF, "allP2");
    checkOutput("allPendDone", 32'(event_pending), 32'h0);
    readReg(2'd3, 32'hC0DE0002, "allStatus");

    checkOutput("sbEmpty", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
